// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute-stage ALU with the CPSR flag register and the EX/MEM
// pipeline register.
//
// Function: evaluates the ARM condition code against NZCV, executes the 16
// data-processing opcodes, and registers the result and writeback control
// for the MEM stage. Latency is one cycle.
//
// Optional build macro: ALU_EX_PERF_EN adds the perf_exec_o and perf_cfail_o
// 32-bit event counters.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   valid_i               instruction present in EX
//   stall_i               MEM stage cannot accept; hold all state
//   flush_i               kill the instruction in EX (priority over stall_i)
//   cond_i, opcode_i      instr[31:28] and instr[24:21]
//   set_flags_i           S bit
//   rn_data_i, alu_op2_i  operand 1, and operand 2 from the shifter
//   shifter_carry_i       shifter carry-out, used as C for logical ops
//   rd_addr_i             destination register
//   carry_to_shifter_o    current C flag (combinational from the flag register)
//   flags_o               NZCV flag register
//   mem_*_o               EX/MEM pipeline register
//   perf_exec_o           executed-instruction count (ALU_EX_PERF_EN only)
//   perf_cfail_o          condition-failed count (ALU_EX_PERF_EN only)
module alu_ex_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [3:0]            cond_i,
    input  logic [3:0]            opcode_i,
    input  logic                  set_flags_i,
    input  logic [DATA_W-1:0]     rn_data_i,
    input  logic [DATA_W-1:0]     alu_op2_i,
    input  logic                  shifter_carry_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  carry_to_shifter_o,
    output logic [3:0]            flags_o,
    output logic                  mem_valid_o,
    output logic [DATA_W-1:0]     mem_result_o,
    output logic [REG_ADDR_W-1:0] mem_rd_addr_o,
    output logic                  mem_wr_en_o
`ifdef ALU_EX_PERF_EN
    ,
    output logic [31:0]           perf_exec_o,
    output logic [31:0]           perf_cfail_o
`endif
);

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    logic [3:0]            flags_q, flags_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0]     mem_result_q, mem_result_d;
    logic [REG_ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic                  mem_wr_en_q, mem_wr_en_d;

    logic flag_n, flag_z, flag_c, flag_v;
    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition evaluation over the current NZCV.
    logic cond_pass;
    always_comb begin
        cond_pass = 1'b0;
        unique case (cond_i)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = ~flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = ~flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = ~flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = ~flag_v;
            4'h8: cond_pass = flag_c & ~flag_z;
            4'h9: cond_pass = ~flag_c | flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
            4'hD: cond_pass = flag_z | (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            4'hF: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

    logic exec;
    logic is_test;
    assign exec    = valid_i & cond_pass & ~flush_i;
    assign is_test = (opcode_i[3:2] == 2'b10);

    // Adder operand selection; subtraction is a + ~b + cin.
    logic              is_arith;
    logic [DATA_W-1:0] add_a, add_b;
    logic              add_cin;
    logic [DATA_W:0]   sum;
    logic              add_v;
    always_comb begin
        is_arith = 1'b1;
        add_a    = rn_data_i;
        add_b    = alu_op2_i;
        add_cin  = 1'b0;
        unique case (opcode_i)
            OP_SUB, OP_CMP: begin add_b = ~alu_op2_i; add_cin = 1'b1; end
            OP_RSB: begin add_a = alu_op2_i; add_b = ~rn_data_i; add_cin = 1'b1; end
            OP_ADD, OP_CMN: add_cin = 1'b0;
            OP_ADC: add_cin = flag_c;
            OP_SBC: begin add_b = ~alu_op2_i; add_cin = flag_c; end
            OP_RSC: begin add_a = alu_op2_i; add_b = ~rn_data_i; add_cin = flag_c; end
            default: is_arith = 1'b0;
        endcase
    end

    assign sum   = {1'b0, add_a} + {1'b0, add_b} + (DATA_W+1)'(add_cin);
    // Overflow when both addends share a sign that the result does not.
    assign add_v = (add_a[DATA_W-1] == add_b[DATA_W-1]) &
                   (sum[DATA_W-1] != add_a[DATA_W-1]);

    // Result mux.
    logic [DATA_W-1:0] result;
    always_comb begin
        result = sum[DATA_W-1:0];
        unique case (opcode_i)
            OP_AND, OP_TST: result = rn_data_i & alu_op2_i;
            OP_EOR, OP_TEQ: result = rn_data_i ^ alu_op2_i;
            OP_ORR:         result = rn_data_i | alu_op2_i;
            OP_MOV:         result = alu_op2_i;
            OP_BIC:         result = rn_data_i & ~alu_op2_i;
            OP_MVN:         result = ~alu_op2_i;
            default:        result = sum[DATA_W-1:0];
        endcase
    end

    // Next state: flush forces a bubble through exec=0 even while stalled.
    logic load;
    assign load = ~stall_i | flush_i;

    always_comb begin
        flags_d       = flags_q;
        mem_valid_d   = mem_valid_q;
        mem_result_d  = mem_result_q;
        mem_rd_addr_d = mem_rd_addr_q;
        mem_wr_en_d   = mem_wr_en_q;
        if (load) begin
            mem_valid_d   = exec;
            mem_result_d  = result;
            mem_rd_addr_d = rd_addr_i;
            mem_wr_en_d   = exec & ~is_test;
            if (exec & (set_flags_i | is_test)) begin
                flags_d[3] = result[DATA_W-1];
                flags_d[2] = (result == '0);
                flags_d[1] = is_arith ? sum[DATA_W] : shifter_carry_i;
                flags_d[0] = is_arith ? add_v : flag_v;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flags_q       <= '0;
            mem_valid_q   <= 1'b0;
            mem_result_q  <= '0;
            mem_rd_addr_q <= '0;
            mem_wr_en_q   <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            mem_valid_q   <= mem_valid_d;
            mem_result_q  <= mem_result_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_wr_en_q   <= mem_wr_en_d;
        end
    end

    assign flags_o            = flags_q;
    assign carry_to_shifter_o = flags_q[1];
    assign mem_valid_o        = mem_valid_q;
    assign mem_result_o       = mem_result_q;
    assign mem_rd_addr_o      = mem_rd_addr_q;
    assign mem_wr_en_o        = mem_wr_en_q;

`ifdef ALU_EX_PERF_EN
    // Event counters; both wrap naturally at 2^32.
    logic [31:0] perf_exec_q, perf_exec_d;
    logic [31:0] perf_cfail_q, perf_cfail_d;

    always_comb begin
        perf_exec_d  = perf_exec_q;
        perf_cfail_d = perf_cfail_q;
        if (exec & ~stall_i)
            perf_exec_d = perf_exec_q + 32'd1;
        if (valid_i & ~cond_pass & ~flush_i & ~stall_i)
            perf_cfail_d = perf_cfail_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_exec_q  <= '0;
            perf_cfail_q <= '0;
        end else begin
            perf_exec_q  <= perf_exec_d;
            perf_cfail_q <= perf_cfail_d;
        end
    end

    assign perf_exec_o  = perf_exec_q;
    assign perf_cfail_o = perf_cfail_q;
`else
    // No event counters in this build.
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed testbench for alu_ex_stage with hand-computed expected values.
module tb_alu_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [3:0]  cond_i;
    logic [3:0]  opcode_i;
    logic        set_flags_i;
    logic [31:0] rn_data_i;
    logic [31:0] alu_op2_i;
    logic        shifter_carry_i;
    logic [3:0]  rd_addr_i;
    logic        carry_to_shifter_o;
    logic [3:0]  flags_o;
    logic        mem_valid_o;
    logic [31:0] mem_result_o;
    logic [3:0]  mem_rd_addr_o;
    logic        mem_wr_en_o;
`ifdef ALU_EX_PERF_EN
    logic [31:0] perf_exec_o;
    logic [31:0] perf_cfail_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    alu_ex_stage dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .valid_i            (valid_i),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .cond_i             (cond_i),
        .opcode_i           (opcode_i),
        .set_flags_i        (set_flags_i),
        .rn_data_i          (rn_data_i),
        .alu_op2_i          (alu_op2_i),
        .shifter_carry_i    (shifter_carry_i),
        .rd_addr_i          (rd_addr_i),
        .carry_to_shifter_o (carry_to_shifter_o),
        .flags_o            (flags_o),
        .mem_valid_o        (mem_valid_o),
        .mem_result_o       (mem_result_o),
        .mem_rd_addr_o      (mem_rd_addr_o),
        .mem_wr_en_o        (mem_wr_en_o)
`ifdef ALU_EX_PERF_EN
        ,
        .perf_exec_o        (perf_exec_o),
        .perf_cfail_o       (perf_cfail_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] op, input logic s,
                         input logic [31:0] rn, input logic [31:0] op2,
                         input logic sc, input logic [3:0] rd);
        valid_i         = 1'b1;
        cond_i          = c;
        opcode_i        = op;
        set_flags_i     = s;
        rn_data_i       = rn;
        alu_op2_i       = op2;
        shifter_carry_i = sc;
        rd_addr_i       = rd;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        cond_i = 4'h0; opcode_i = 4'h0; set_flags_i = 1'b0;
        rn_data_i = '0; alu_op2_i = '0; shifter_carry_i = 1'b0; rd_addr_i = '0;
        #3;
        chk("rst_flags", 32'(flags_o), 32'h0);
        chk("rst_valid", 32'(mem_valid_o), 32'h0);
        chk("rst_result", mem_result_o, 32'h0);
        chk("rst_rd", 32'(mem_rd_addr_o), 32'h0);
        chk("rst_wr", 32'(mem_wr_en_o), 32'h0);
        #9 rst_n_i = 1'b1;

        // ADDS overflow into the sign bit
        drive(4'hE, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd3);
        tick();
        chk("adds_result", mem_result_o, 32'h8000_0000);
        chk("adds_flags", 32'(flags_o), 32'h9);
        chk("adds_wr", 32'(mem_wr_en_o), 32'h1);
        chk("adds_valid", 32'(mem_valid_o), 32'h1);
        chk("adds_rd", 32'(mem_rd_addr_o), 32'h3);

        // CMP with S=0 still writes flags
        drive(4'hE, 4'hA, 1'b0, 32'd5, 32'd5, 1'b0, 4'd4);
        tick();
        chk("cmp_flags", 32'(flags_o), 32'h6);
        chk("cmp_wr", 32'(mem_wr_en_o), 32'h0);
        chk("cmp_valid", 32'(mem_valid_o), 32'h1);

        // MOVNE fails with Z=1
        drive(4'h1, 4'hD, 1'b1, 32'h0, 32'd7, 1'b0, 4'd5);
        tick();
        chk("movne_valid", 32'(mem_valid_o), 32'h0);
        chk("movne_wr", 32'(mem_wr_en_o), 32'h0);
        chk("movne_flags", 32'(flags_o), 32'h6);

        // MOVEQ passes
        drive(4'h0, 4'hD, 1'b0, 32'h0, 32'd7, 1'b0, 4'd5);
        tick();
        chk("moveq_result", mem_result_o, 32'd7);
        chk("moveq_wr", 32'(mem_wr_en_o), 32'h1);
        chk("moveq_flags", 32'(flags_o), 32'h6);

        // Set V=1, then MOVS keeps V and takes C from the shifter
        drive(4'hE, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd1);
        tick();
        chk("adds2_flags", 32'(flags_o), 32'h9);
        drive(4'hE, 4'hD, 1'b1, 32'h0, 32'h0, 1'b1, 4'd2);
        tick();
        chk("movs_flags", 32'(flags_o), 32'h7);
        chk("movs_carry_out", 32'(carry_to_shifter_o), 32'h1);

        // ADCS / SBCS chain with C=1
        drive(4'hE, 4'h5, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'd6);
        tick();
        chk("adcs_result", mem_result_o, 32'h0);
        chk("adcs_flags", 32'(flags_o), 32'h6);
        drive(4'hE, 4'h6, 1'b1, 32'h0, 32'h0, 1'b0, 4'd7);
        tick();
        chk("sbcs_result", mem_result_o, 32'h0);
        chk("sbcs_flags", 32'(flags_o), 32'h6);
        chk("sbcs_rd", 32'(mem_rd_addr_o), 32'h7);

        // SUBS held by stall for 3 cycles
        drive(4'hE, 4'h2, 1'b1, 32'd3, 32'd10, 1'b0, 4'd9);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rd", 32'(mem_rd_addr_o), 32'h7);
            chk("stall_flags", 32'(flags_o), 32'h6);
            chk("stall_carry", 32'(carry_to_shifter_o), 32'h1);
        end
        stall_i = 1'b0;
        tick();
        chk("subs_result", mem_result_o, 32'hFFFF_FFF9);
        chk("subs_flags", 32'(flags_o), 32'h8);
        chk("subs_carry", 32'(carry_to_shifter_o), 32'h0);

        // Flush wins over stall
        drive(4'hE, 4'h2, 1'b1, 32'd1, 32'd1, 1'b0, 4'd10);
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        chk("flush_valid", 32'(mem_valid_o), 32'h0);
        chk("flush_wr", 32'(mem_wr_en_o), 32'h0);
        chk("flush_flags", 32'(flags_o), 32'h8);
        stall_i = 1'b0;
        flush_i = 1'b0;

        // NV never executes
        drive(4'hF, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd11);
        tick();
        chk("nv_valid", 32'(mem_valid_o), 32'h0);
        chk("nv_flags", 32'(flags_o), 32'h8);

        // Flag-setting op, then asynchronous reset between edges
        drive(4'hE, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd12);
        tick();
        chk("pre_rst_flags", 32'(flags_o), 32'h9);
`ifdef ALU_EX_PERF_EN
        chk("perf_exec", perf_exec_o, 32'd9);
        chk("perf_cfail", perf_cfail_o, 32'd2);
`endif
        valid_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_flags", 32'(flags_o), 32'h0);
        chk("arst_valid", 32'(mem_valid_o), 32'h0);
        chk("arst_carry", 32'(carry_to_shifter_o), 32'h0);
`ifdef ALU_EX_PERF_EN
        chk("arst_perf_exec", perf_exec_o, 32'h0);
        chk("arst_perf_cfail", perf_cfail_o, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
Execute-stage ALU plus EX/MEM pipeline register. It sits directly downstream of the operand-2 shifter and consumes its operand-2 and shifter carry-out. It evaluates the ARM condition code against the CPSR flags held in this block, then performs the 16 data-processing opcodes. It registers the result and writeback control for the MEM stage and feeds the current C flag back to the shifter as its carry input.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
REG_ADDR_W, 4, register-index width.

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
valid_i  input  1  instruction present in EX
stall_i  input  1  MEM stage cannot accept; hold all state
flush_i  input  1  kill the instruction currently in EX
cond_i  input  4  instr[31:28]
opcode_i  input  4  instr[24:21]
set_flags_i  input  1  S bit
rn_data_i  input  32  operand 1
alu_op2_i  input  32  operand 2 from the shifter
shifter_carry_i  input  1  carry-out from the shifter
rd_addr_i  input  4  destination register
carry_to_shifter_o  output  1  current C flag (combinational from flag register)
flags_o  output  4  NZCV flag register
mem_valid_o  output  1  EX/MEM valid
mem_result_o  output  32  EX/MEM ALU result
mem_rd_addr_o  output  4  EX/MEM destination
mem_wr_en_o  output  1  EX/MEM register-write enable

Behaviour:
- Reset (asynchronous, rst_n_i low): flags_o=0, mem_valid_o=0, mem_result_o=0, mem_rd_addr_o=0, mem_wr_en_o=0.
- Latency is 1 cycle: the EX result appears on the mem_* outputs after the next rising edge. Flags update on that same edge, so the following instruction sees the new flags with no hazard.
- Condition pass uses the standard ARM table EQ..AL over NZCV. cond=1111 (NV) never passes.
- exec = valid_i & cond_pass & ~flush_i.
- Opcodes: AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN (0000..1111).
- Arithmetic: 33-bit add.
  - SUB is rn + ~op2 + 1; RSB is op2 + ~rn + 1; SBC/RSC carry-in is the C flag.
  - C = bit 32 (for subtraction, C = NOT borrow).
  - V = signed overflow of the 32-bit result.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = shifter_carry_i; V unchanged.
- N = result[31]; Z = (result==0).
- Flags written only when exec & (set_flags_i | opcode is TST/TEQ/CMP/CMN).
- Writeback: mem_wr_en_o = exec & opcode not in {TST, TEQ, CMP, CMN}.
- mem_valid_o = exec. On a condition-failed instruction: mem_valid_o=0, mem_wr_en_o=0, flags unchanged.
- mem_result_o and mem_rd_addr_o load on every non-stalled cycle. Their values are don't-care when mem_valid_o=0.
- stall_i=1 (without flush): all registers, flags and counters hold; the inputs are expected to be held by upstream.
- flush_i=1: priority over stall_i. The EX/MEM register loads a bubble (valid=0, wr_en=0) and flags hold.
- carry_to_shifter_o always equals flags_o[1], including during stall.
- Reset asserted mid-operation clears state immediately; no partial flag update survives.

Optional Feature:
ALU_EX_PERF_EN: adds two 32-bit counters and their outputs.
- perf_exec_o counts cycles with exec=1 & ~stall_i.
- perf_cfail_o counts cycles with valid_i & ~cond_pass & ~flush_i & ~stall_i.
- Both reset to 0 and wrap at 2^32.
- Without the macro, neither the ports nor the logic exist.

Test Plan:
- ADDS: rn=0x7FFFFFFF, op2=1, S=1, cond=AL -> mem_result_o=0x80000000, NZCV=1001, mem_wr_en_o=1 one cycle later.
- CMP then conditional: CMP rn=5, op2=5 -> NZCV=0110, mem_wr_en_o=0. Next, MOVNE op2=7 -> mem_valid_o=0, flags unchanged; MOVEQ op2=7 -> result 7, write enabled.
- Logical carry: MOVS op2=0, shifter_carry_i=1 with prior V=1 -> NZCV=0111. The next cycle shows carry_to_shifter_o=1.
- ADC/SBC chain: C=1; ADC rn=0xFFFFFFFF, op2=0 -> result 0, C=1, Z=1 (S set). Then SBC rn=0, op2=0 with C=1 -> result 0, C=1.
- Stall/flush: stall_i=1 for 3 cycles with a SUBS in EX -> mem_* and flags frozen. Then flush_i=1 together with stall_i=1 -> mem_valid_o=0 next edge, flags unchanged.
- Reset mid-run: assert rst_n_i low between clock edges after a flag-setting op -> flags_o=0 and mem_valid_o=0 immediately, asynchronously. With ALU_EX_PERF_EN, the counters also read 0.
